// File: rtl/pipe_subtractor.sv
// pipe_subtractor
//   Pipelined ripple-borrow subtractor. Each of the WIDTH/2 stages resolves
//   two difference bits, using the borrow registered by the stage before it.
//   The stages form a single lock-step pipeline with one valid bit per stage.
//   The whole pipeline freezes only while the last stage holds a result that
//   the consumer is not taking.
//
// Parameters
//   WIDTH      operand width in bits (even, >= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every stage
//   in_valid   an operand set is presented on a/b/bin
//   in_ready   pipeline can accept an operand set this cycle
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  diff/bout/ovf hold a result
//   out_ready  consumer takes the result on this edge
//   diff       (a - b - bin) mod 2^WIDTH
//   bout       unsigned borrow out (a < b + bin)
//   ovf        two's-complement signed overflow

module pipe_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / 2;

  // Holding the whole pipeline on a stall keeps it simple: bubbles are never
  // collapsed, so the same signal gates every stage.
  logic stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // RW is the number of operand bits not yet consumed on entry to stage k.
    // The stage consumes the two LSBs of that slice and forwards the rest,
    // so each stage carries only what later stages still need.
    localparam int RW = WIDTH - 2 * k;

    logic [RW-1:0]  src_a;
    logic [RW-1:0]  src_b;
    logic           src_brw;
    logic           src_vld;
    logic [2:0]     part;
    logic [2*k+1:0] next_d;

    logic           v_q;
    logic           br_q;
    logic [2*k+1:0] d_q;

    // Stage 0 takes its data from the ports. Later stages take it from the
    // registers of the previous stage. The difference bits accumulate LSB
    // first, so stage k holds the low 2k+2 bits of the result.
    if (k == 0) begin : g_src
      assign src_a   = a;
      assign src_b   = b;
      assign src_brw = bin;
      assign src_vld = in_valid;
      assign next_d  = part[1:0];
    end else begin : g_src
      assign src_a   = g_stage[k-1].g_fwd.a_q;
      assign src_b   = g_stage[k-1].g_fwd.b_q;
      assign src_brw = g_stage[k-1].br_q;
      assign src_vld = g_stage[k-1].v_q;
      assign next_d  = {part[1:0], g_stage[k-1].d_q};
    end

    // A 3-bit subtraction of two 2-bit digits. A negative result wraps, which
    // sets bit 2, and bit 2 is therefore the borrow into the next digit.
    assign part = {1'b0, src_a[1:0]} - {1'b0, src_b[1:0]} - {2'b00, src_brw};

    // Valid bit, borrow and partial difference for this stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        br_q <= 1'b0;
        d_q  <= '0;
      end else if (!stall) begin
        v_q  <= src_vld;
        br_q <= part[2];
        d_q  <= next_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-3:0] a_q;
      logic [RW-3:0] b_q;

      // Forward the operand bits that the later stages still have to consume.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= src_a[RW-1:2];
          b_q <= src_b[RW-1:2];
        end
      end
    end else begin : g_last
      logic ov_q;

      // The last stage sees both operand MSBs and also produces the result
      // MSB (part[1]), so the signed overflow is computed and registered here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
        end else if (!stall) begin
          ov_q <= (src_a[RW-1] != src_b[RW-1]) && (part[1] != src_a[RW-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign diff      = g_stage[STAGES-1].d_q;
  assign bout      = g_stage[STAGES-1].br_q;
  assign ovf       = g_stage[STAGES-1].g_last.ov_q;

endmodule

// File: doc/pipe_subtractor.md
PIPE_SUBTRACTOR -- requirements
Module: pipe_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits, even and >= 2.
REQ-002 The block SHALL have these ports, and no others:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  difference.
- bout  output  1  unsigned borrow out.
- ovf  output  1  two's-complement signed overflow.

Function
REQ-003 The block SHALL compute diff = (a - b - bin) mod 2^WIDTH.
REQ-004 The block SHALL set bout = 1 iff a < b + bin, compared unsigned.
REQ-005 The block SHALL set ovf = 1 iff a[WIDTH-1] != b[WIDTH-1] and diff[WIDTH-1] != a[WIDTH-1].
REQ-006 The datapath SHALL be a ripple-borrow pipeline of WIDTH/2 stages; stage k:
- resolves diff bits [2k+1:2k] from the borrow registered by stage k-1 (bin for k = 0);
- registers the resolved bits, the borrow, and the not-yet-used operand bits forward, one valid bit per stage.
REQ-007 Latency SHALL be exactly WIDTH/2 cycles, from the accepting edge (in_valid && in_ready) to out_valid = 1, when no stall occurs (4 cycles at WIDTH = 8).
REQ-008 Throughput SHALL be one operand set per cycle with no stall.
REQ-009 A transfer SHALL occur on a rising edge:
- input side when in_valid && in_ready;
- output side when out_valid && out_ready.
REQ-010 A stall SHALL be out_valid && !out_ready.
- During a stall, every pipeline register, including valid bits, SHALL hold its value.
- in_ready SHALL be 0 during a stall and 1 otherwise, combinationally.
REQ-011 Bubbles SHALL NOT be collapsed; an empty stage advances like a full one when not stalled.
REQ-012 diff, bout, ovf and out_valid SHALL be driven directly from the last stage registers; there is no combinational path from a, b or bin to the outputs.
REQ-013 diff, bout and ovf SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-014 Results SHALL leave in acceptance order; no result is dropped or duplicated.
REQ-015 Operands presented while in_ready = 0 SHALL be ignored.
REQ-016 If in_valid = 0 on a non-stall edge, stage 0 SHALL load valid = 0.
REQ-017 If out_ready = 1 and the last stage is empty, there SHALL be no effect.

Reset
REQ-018 While rst_n = 0, independent of clk, all stage valid bits and data registers SHALL clear to 0:
- out_valid = 0, diff = 0, bout = 0, ovf = 0, in_ready = 1.
REQ-019 Assertion of rst_n mid-operation SHALL discard all in-flight results; none SHALL appear after release.
REQ-020 The first operand accepted on or after the first rising edge with rst_n = 1 SHALL produce its result after WIDTH/2 cycles.

Verification (WIDTH = 8, out_ready = 1 unless stated)
REQ-021 Scenario: rst_n low -> out_valid = 0, diff = 0x00, bout = 0, ovf = 0, in_ready = 1 without a clock edge.
REQ-022 Scenario: a = 0x05, b = 0x03, bin = 0 -> 4 cycles later diff = 0x02, bout = 0, ovf = 0.
REQ-023 Scenario: a = 0x00, b = 0x01, bin = 0 -> diff = 0xFF, bout = 1, ovf = 0; a = 0x00, b = 0xFF, bin = 1 -> diff = 0x00, bout = 1, ovf = 0.
REQ-024 Scenario: a = 0x80, b = 0x01, bin = 0 -> diff = 0x7F, bout = 0, ovf = 1; a = 0x7F, b = 0xFF -> diff = 0x80, bout = 1, ovf = 1.
REQ-025 Scenario: back-to-back pipeline sequence:
- stimulus: 6 back-to-back operands (a = 0x10..0x15, b = 0x01, bin = 0); out_ready = 0 for 3 cycles after the first out_valid.
- required response: in_ready = 0 and outputs held for those 3 cycles; then diff = 0x0F..0x14 in order, one per cycle, with no loss or duplication.
REQ-026 Scenario: rst_n pulsed low for 1 cycle with 3 operands in flight -> no out_valid afterwards until new operands are accepted; the next operand's result appears 4 cycles after acceptance.
